// File: rtl/de_regfile_scoreboard_pkg.sv
// Shared types for the decode-side register file and writer scoreboard.
// The optional same-cycle WB bypass is enabled by defining REGFILE_WB_BYPASS_EN.
package de_regfile_scoreboard_pkg;

  localparam int NREGS     = 32;
  localparam int REGNOBITS = 5;
  localparam int DBITS     = 32;
  localparam int CNTBITS   = 3;

  typedef logic [REGNOBITS-1:0] regno_t;
  typedef logic [DBITS-1:0]     word_t;
  typedef logic [CNTBITS-1:0]   cnt_t;

  localparam cnt_t CNT_MAX = '1;

  // Field order matches the from_WB_to_DE bundle: {wr_reg, wregno, regval}.
  typedef struct packed {
    logic   wr_reg;
    regno_t wregno;
    word_t  regval;
  } wb_to_de_t;

  function automatic logic is_x0(regno_t r);
    return r == '0;
  endfunction

endpackage

// File: rtl/de_regfile_scoreboard_sb_counter.sv
// Per-register in-flight writer counter: saturating up/down with underflow flag.
// Used by de_regfile_scoreboard (REGFILE_WB_BYPASS_EN does not affect this block).
module sb_counter
  import de_regfile_scoreboard_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               inc,
  input  logic               dec,
  output logic [CNTBITS-1:0] cnt,
  output logic               at_max,
  output logic               underflow
);

  cnt_t cnt_q, cnt_d;

  // Simultaneous issue and writeback cancel; a writeback with nothing
  // outstanding leaves the count at zero and reports underflow.
  always_comb begin
    cnt_d     = cnt_q;
    underflow = 1'b0;
    if (inc && !dec) begin
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNTBITS'(1);
    end else if (dec && !inc) begin
      if (cnt_q == '0) underflow = 1'b1;
      else             cnt_d     = cnt_q - CNTBITS'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt    = cnt_q;
  assign at_max = (cnt_q == CNT_MAX);

endmodule

// File: rtl/de_regfile_scoreboard.sv
// Architectural register file with two combinational read ports, WB write port and
// a counting RAW/WAW scoreboard. Define REGFILE_WB_BYPASS_EN for same-cycle WB bypass.
module de_regfile_scoreboard
  import de_regfile_scoreboard_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wb_wr_en,
  input  logic [REGNOBITS-1:0] wb_wregno,
  input  logic [DBITS-1:0]     wb_regval,
  input  logic [REGNOBITS-1:0] rs1,
  input  logic [REGNOBITS-1:0] rs2,
  input  logic                 rs1_used,
  input  logic                 rs2_used,
  input  logic                 rd_issue_en,
  input  logic [REGNOBITS-1:0] rd_issue,
  output logic [DBITS-1:0]     rs1_val,
  output logic [DBITS-1:0]     rs2_val,
  output logic                 stall,
  output logic                 err_underflow
);

  wb_to_de_t wb;
  assign wb = '{wr_reg: wb_wr_en, wregno: wb_wregno, regval: wb_regval};

  logic wb_we;
  assign wb_we = wb.wr_reg && !is_x0(wb.wregno);

  logic [NREGS-1:0][DBITS-1:0] regs_q, regs_d;
  logic                        err_underflow_q, err_underflow_d;

  // x0 owns no counter; its slots in the full-width views stay zero.
  logic [NREGS-1:1][CNTBITS-1:0] cnt;
  logic [NREGS-1:1]              at_max, underflow;
  logic [NREGS-1:0][CNTBITS-1:0] cnt_all;
  logic [NREGS-1:0]              at_max_all;
  logic                          issue_ok;

  assign issue_ok = rd_issue_en && !stall && !is_x0(rd_issue);

  for (genvar r = 1; r < NREGS; r++) begin : g_cnt
    sb_counter u_cnt (
      .clk       (clk),
      .reset     (reset),
      .inc       (issue_ok && rd_issue == REGNOBITS'(r)),
      .dec       (wb_we && wb.wregno == REGNOBITS'(r)),
      .cnt       (cnt[r]),
      .at_max    (at_max[r]),
      .underflow (underflow[r])
    );
  end

  always_comb begin
    cnt_all    = '0;
    at_max_all = '0;
    for (int r = 1; r < NREGS; r++) begin
      cnt_all[r]    = cnt[r];
      at_max_all[r] = at_max[r];
    end
  end

  // Register array and sticky error
  always_comb begin
    regs_d = regs_q;
    if (wb_we) regs_d[wb.wregno] = wb.regval;
    regs_d[0]       = '0;
    err_underflow_d = err_underflow_q | (|underflow);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q          <= '0;
      err_underflow_q <= 1'b0;
    end else begin
      regs_q          <= regs_d;
      err_underflow_q <= err_underflow_d;
    end
  end

  assign err_underflow = err_underflow_q;

  // Read ports
  always_comb begin
    rs1_val = is_x0(rs1) ? '0 : regs_q[rs1];
    rs2_val = is_x0(rs2) ? '0 : regs_q[rs2];
`ifdef REGFILE_WB_BYPASS_EN
    if (wb_we && wb.wregno == rs1) rs1_val = wb.regval;
    if (wb_we && wb.wregno == rs2) rs2_val = wb.regval;
`endif
  end

  // Hazard detection
  logic rs1_busy, rs2_busy, sat;

  always_comb begin
    rs1_busy = !is_x0(rs1) && (cnt_all[rs1] != '0);
    rs2_busy = !is_x0(rs2) && (cnt_all[rs2] != '0);
`ifdef REGFILE_WB_BYPASS_EN
    // The last outstanding writer retiring this cycle is forwarded, so no hazard.
    if (cnt_all[rs1] == CNTBITS'(1) && wb_we && wb.wregno == rs1) rs1_busy = 1'b0;
    if (cnt_all[rs2] == CNTBITS'(1) && wb_we && wb.wregno == rs2) rs2_busy = 1'b0;
`endif
    sat   = rd_issue_en && at_max_all[rd_issue];
    stall = (rs1_busy && rs1_used) || (rs2_busy && rs2_used) || sat;
  end

endmodule
